fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage: owns the program counter, drives the fetch address into the combinational instruction memory, and registers the returned word into the IF/ID pipeline register. Resolves next-PC selection among sequential, branch/jump redirect, exception-vector entry and `eret` return. Flags fetch address faults (AdEL) and marks branch-delay-slot instructions so downstream exception logic can form EPC.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded at reset
- `HANDLER_PC`, 32'h0000_4180, exception entry vector
- `IM_START`, 32'h0000_3000, first valid fetch byte address
- `IM_SIZE`, 32'h0000_4000, fetchable region size in bytes
- `clk  in  1`  rising-edge clock
- `rst_n  in  1`  reset, asynchronous, active-low
- `stall  in  1`  hold PC and IF/ID register
- `redirect  in  1`  branch/jump taken, from ID
- `redirect_pc  in  32`  branch/jump target
- `exc_enter  in  1`  exception/interrupt taken, from CP0
- `eret  in  1`  exception return, from CP0
- `epc  in  32`  return address for `eret`
- `im_pc  out  32`  fetch address to instruction memory
- `im_code  in  32`  instruction word from instruction memory (combinational)
- `id_pc  out  32`  registered PC of instruction in ID
- `id_code  out  32`  registered instruction word
- `id_valid  out  1`  ID holds a real instruction
- `id_exccode  out  5`  fetch exception code (0 none, 4 AdEL)
- `id_bd  out  1`  instruction is a branch delay slot

## Operation
- `im_pc` = PC register, combinationally.
- Next-PC priority, high to low: `exc_enter` → `HANDLER_PC`; `eret` → `epc`; `stall` → hold; `redirect` → `redirect_pc`; else PC+4 (32-bit wrap, no saturation).
- IF/ID update, same priority:
  - `exc_enter` or `eret`: flush — `id_valid`=0, `id_code`=0, `id_exccode`=0, `id_bd`=0, `id_pc`=current PC.
  - `stall`: all `id_*` hold.
  - otherwise: `id_pc`=PC, `id_valid`=1, `id_bd`=`redirect`, `id_exccode`/`id_code` per fault check.
- Fault check on current PC: PC[1:0]≠0 → fault. Faulting fetch: `id_exccode`=4, `id_code`=0 (nop), `im_code` ignored. Otherwise `id_exccode`=0, `id_code`=`im_code`.
- `redirect` during `stall` is dropped; ID re-asserts it when unstalled.
- Delay-slot semantics: a redirect does not flush IF/ID; the word fetched in the redirect cycle is the delay slot and is registered with `id_bd`=1.
- A faulting PC keeps advancing until CP0 asserts `exc_enter`; no internal halt.

## Timing
- Reset (asserted any time, mid-stall included): PC=`RESET_PC`, `id_pc`=0, `id_code`=0, `id_valid`=0, `id_exccode`=0, `id_bd`=0, immediately.
- First edge after `rst_n` rises: `id_pc`=`RESET_PC`, `id_valid`=1.
- Fetch-to-ID latency: 1 cycle. Redirect-to-target-in-ID: 2 cycles (delay slot between).
- `exc_enter` and `eret` same cycle: `exc_enter` wins.
- `exc_enter` with `stall`: exception wins; stall ignored that cycle.

## Configuration
- `FETCH_RANGE_CHECK_EN` defined: fault also when PC < `IM_START` or PC ≥ `IM_START`+`IM_SIZE` (compare without overflow, 33-bit).
- Undefined: alignment check only; out-of-range fetches pass `im_code` through unchanged.

## Test plan
- Release reset, no stall, 4 cycles → `id_pc` = 0x3000, 0x3004, 0x3008, 0x300C, `id_valid`=1, `id_bd`=0.
- `stall` high 2 cycles at PC 0x3008 → PC and all `id_*` hold 2 cycles, then `id_pc`=0x3008 → 0x300C resumes.
- `redirect`=1, `redirect_pc`=0x3100 at PC 0x3010 → next `id_pc`=0x3010 with `id_bd`=1, then `id_pc`=0x3100 with `id_bd`=0.
- `exc_enter` and `eret` together with `stall`, PC 0x3020 → `id_valid`=0, then `id_pc`=0x4180, `id_valid`=1.
- `redirect_pc`=0x3102 → `id_pc`=0x3102, `id_exccode`=4, `id_code`=0; with `FETCH_RANGE_CHECK_EN`, `redirect_pc`=0x8000 → `id_exccode`=4, without → 0 and `id_code`=`im_code`.
- Assert `rst_n`=0 mid-stall at PC 0x3040 → all outputs reset values before next edge, PC=0x3000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID pipeline register.
// Optional FETCH_RANGE_CHECK_EN adds an out-of-region fetch fault on top of the alignment check.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_START   = 32'h0000_3000,
  parameter logic [31:0] IM_SIZE    = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exc_enter,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] im_pc,
  input  logic [31:0] im_code,
  output logic [31:0] id_pc,
  output logic [31:0] id_code,
  output logic        id_valid,
  output logic [4:0]  id_exccode,
  output logic        id_bd
);

  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic        w_fault;
  logic        w_flush;

  logic [31:0] r_id_pc;
  logic [31:0] r_id_code;
  logic        r_id_valid;
  logic [4:0]  r_id_exccode;
  logic        r_id_bd;

  assign im_pc   = r_pc;
  assign w_flush = exc_enter | eret;

`ifdef FETCH_RANGE_CHECK_EN
  // 33-bit compare so IM_START + IM_SIZE cannot wrap past the top of memory.
  logic [32:0] w_pc_ext;
  logic [32:0] w_lo;
  logic [32:0] w_hi;
  assign w_pc_ext = {1'b0, r_pc};
  assign w_lo     = {1'b0, IM_START};
  assign w_hi     = {1'b0, IM_START} + {1'b0, IM_SIZE};
  assign w_fault  = (r_pc[1:0] != 2'b00) | (w_pc_ext < w_lo) | (w_pc_ext >= w_hi);
`else
  assign w_fault  = (r_pc[1:0] != 2'b00);
`endif

  always_comb begin
    w_pc_next = r_pc + 32'd4;
    if (exc_enter)     w_pc_next = HANDLER_PC;
    else if (eret)     w_pc_next = epc;
    else if (stall)    w_pc_next = r_pc;
    else if (redirect) w_pc_next = redirect_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pc <= RESET_PC;
    else        r_pc <= w_pc_next;
  end

  // IF/ID register: no flush on redirect, so the word fetched alongside it becomes the delay slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_pc      <= 32'h0;
      r_id_code    <= 32'h0;
      r_id_valid   <= 1'b0;
      r_id_exccode <= 5'd0;
      r_id_bd      <= 1'b0;
    end else if (w_flush) begin
      r_id_pc      <= r_pc;
      r_id_code    <= 32'h0;
      r_id_valid   <= 1'b0;
      r_id_exccode <= 5'd0;
      r_id_bd      <= 1'b0;
    end else if (!stall) begin
      r_id_pc      <= r_pc;
      r_id_valid   <= 1'b1;
      r_id_bd      <= redirect;
      r_id_code    <= w_fault ? 32'h0 : im_code;
      r_id_exccode <= w_fault ? EXC_ADEL : 5'd0;
    end
  end

  assign id_pc      = r_id_pc;
  assign id_code    = r_id_code;
  assign id_valid   = r_id_valid;
  assign id_exccode = r_id_exccode;
  assign id_bd      = r_id_bd;

endmodule
